// File: rtl/reset_sequencer.sv
// Reset sequencer: synchronised external reset or software request produces a
// held, then staggered, per-channel reset release with a ready indication.
module reset_sequencer #(
    parameter int N_CH        = 4,
    parameter int SYNC_STAGES = 2,
    parameter int PULSE_CYC   = 16,
    parameter int STAGGER_CYC = 4
) (
    input  logic            Clk,
    input  logic            rst,
    input  logic            sw_req,
    output logic [N_CH-1:0] rst_out,
    output logic            ready,
    output logic [1:0]      rst_cause
);

    localparam int MAXC = (PULSE_CYC > STAGGER_CYC) ? PULSE_CYC : STAGGER_CYC;
    localparam int CW   = $clog2(MAXC + 1);
    localparam int IW   = (N_CH > 1) ? $clog2(N_CH) : 1;

    localparam logic [CW-1:0] ONE       = CW'(1);
    localparam logic [CW-1:0] HOLD_LAST = CW'(PULSE_CYC - 1);
    localparam logic [CW-1:0] STG_LAST  = CW'(STAGGER_CYC - 1);
    localparam logic [IW-1:0] LAST_CH   = IW'(N_CH - 1);
    localparam logic [1:0]    CAUSE_EXT = 2'b01;
    localparam logic [1:0]    CAUSE_SW  = 2'b10;

    typedef enum logic [1:0] {ASSERT, HOLD, RELEASE, DONE} state_t;

    // Power-up values match the asynchronous reset values.
    logic [SYNC_STAGES-1:0] sync    = '1;
    state_t                 state   = ASSERT;
    logic [CW-1:0]          cnt     = '0;
    logic [IW-1:0]          idx     = '0;
    logic [N_CH-1:0]        out_q   = '1;
    logic                   rdy_q   = 1'b0;
    logic [1:0]             cause_q = CAUSE_EXT;

    state_t          state_n;
    logic [CW-1:0]   cnt_n;
    logic [IW-1:0]   idx_n;
    logic [N_CH-1:0] out_n;
    logic            rdy_n;
    logic [1:0]      cause_n;
    logic            rel0;
    logic            sync_out;

    assign sync_out  = sync[SYNC_STAGES-1];
    assign rst_out   = out_q;
    assign ready     = rdy_q;
    assign rst_cause = cause_q;

    always_ff @(posedge Clk or posedge rst) begin
        if (rst) sync <= '1;
        else     sync <= {sync[SYNC_STAGES-2:0], 1'b0};
    end

    always_ff @(posedge Clk or posedge rst) begin
        if (rst) begin
            state   <= ASSERT;
            cnt     <= '0;
            idx     <= '0;
            out_q   <= '1;
            rdy_q   <= 1'b0;
            cause_q <= CAUSE_EXT;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            idx     <= idx_n;
            out_q   <= out_n;
            rdy_q   <= rdy_n;
            cause_q <= cause_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        idx_n   = idx;
        out_n   = out_q;
        rdy_n   = rdy_q;
        cause_n = cause_q;
        rel0    = 1'b0;
        case (state)
            ASSERT: begin
                // The edge that sees the synchroniser low already counts as the
                // first hold cycle, so the hold counter starts at one here.
                if (!sync_out) begin
                    if (PULSE_CYC == 1) begin
                        rel0 = 1'b1;
                    end else begin
                        state_n = HOLD;
                        cnt_n   = ONE;
                    end
                end
            end
            HOLD: begin
                if (cnt == HOLD_LAST) rel0 = 1'b1;
                else                  cnt_n = cnt + ONE;
            end
            RELEASE: begin
                if (cnt == STG_LAST) begin
                    out_n[idx] = 1'b0;
                    cnt_n      = '0;
                    idx_n      = idx + IW'(1);
                    if (idx == LAST_CH) begin
                        state_n = DONE;
                        rdy_n   = 1'b1;
                    end
                end else begin
                    cnt_n = cnt + ONE;
                end
            end
            DONE: begin
                if (sw_req) begin
                    state_n = HOLD;
                    cnt_n   = '0;
                    out_n   = '1;
                    rdy_n   = 1'b0;
                    cause_n = CAUSE_SW;
                end
            end
            default: state_n = ASSERT;
        endcase

        if (rel0) begin
            cnt_n = '0;
            if (N_CH == 1 || STAGGER_CYC == 0) begin
                out_n   = '0;
                rdy_n   = 1'b1;
                state_n = DONE;
            end else begin
                out_n[0] = 1'b0;
                idx_n    = IW'(1);
                state_n  = RELEASE;
            end
        end
    end

endmodule

// File: tb/tb_reset_sequencer.sv
// Scoreboard bench for reset_sequencer: default instance plus a
// two-channel, no-stagger, single-cycle-hold instance on the same stimulus.
module tb_reset_sequencer;

    localparam int S   = 2;
    localparam int BIG = 1 << 30;

    logic       Clk;
    logic       rst;
    logic       sw_req;
    logic [3:0] out0;
    logic       rdy0;
    logic [1:0] cause0;
    logic [1:0] out1;
    logic       rdy1;
    logic [1:0] cause1;

    reset_sequencer #(.N_CH(4), .SYNC_STAGES(2), .PULSE_CYC(16), .STAGGER_CYC(4)) dut0 (
        .Clk(Clk), .rst(rst), .sw_req(sw_req),
        .rst_out(out0), .ready(rdy0), .rst_cause(cause0)
    );

    reset_sequencer #(.N_CH(2), .SYNC_STAGES(2), .PULSE_CYC(1), .STAGGER_CYC(0)) dut1 (
        .Clk(Clk), .rst(rst), .sw_req(sw_req),
        .rst_out(out1), .ready(rdy1), .rst_cause(cause1)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    typedef struct {
        int         n;
        logic [3:0] o0;
        logic       r0;
        logic [1:0] c0;
        logic [1:0] o1;
        logic       r1;
        logic [1:0] c1;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;
    int   edge_no = 0;

    // Reference model: per instance, the edge on which channel 0 releases.
    int         rel0  [2];
    bit         pend  [2];
    logic [1:0] cause [2];
    int         nch   [2] = '{4, 2};
    int         stg   [2] = '{4, 0};
    int         pcyc  [2] = '{16, 1};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s edge=%0d got=%0h exp=%0h", tag, edge_no, got, exp);
        end
    endtask

    function automatic logic [3:0] exp_bits(input int n, input int i);
        logic [3:0] b;
        b = '0;
        for (int k = 0; k < nch[i]; k++)
            b[k] = (n < rel0[i] + k * stg[i]);
        return b;
    endfunction

    function automatic bit is_done(input int n, input int i);
        return !pend[i] && rel0[i] != BIG && (n - 1) >= rel0[i] + (nch[i] - 1) * stg[i];
    endfunction

    // Drives sw for the coming edge, predicts that edge, then checks it.
    task automatic step(input logic sw_v);
        exp_t e;
        exp_t g;
        logic [3:0] b0;
        logic [3:0] b1;
        int n;
        sw_req = sw_v;
        n = edge_no + 1;
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                rel0[i] = BIG; pend[i] = 1'b1; cause[i] = 2'b01;
            end else if (pend[i]) begin
                rel0[i] = n + S - 1 + pcyc[i]; pend[i] = 1'b0;
            end else if (sw_v && is_done(n, i)) begin
                rel0[i] = n + pcyc[i]; cause[i] = 2'b10;
            end
        end
        b0 = exp_bits(n, 0);
        b1 = exp_bits(n, 1);
        e.n = n;
        e.o0 = b0;      e.r0 = (b0 == 4'b0000); e.c0 = cause[0];
        e.o1 = b1[1:0]; e.r1 = (b1 == 4'b0000); e.c1 = cause[1];
        q.push_back(e);
        @(posedge Clk);
        edge_no++;
        #1;
        g = q.pop_front();
        chk("out0",   32'(out0),   32'(g.o0));
        chk("ready0", 32'(rdy0),   32'(g.r0));
        chk("cause0", 32'(cause0), 32'(g.c0));
        chk("out1",   32'(out1),   32'(g.o1));
        chk("ready1", 32'(rdy1),   32'(g.r1));
        chk("cause1", 32'(cause1), 32'(g.c1));
        @(negedge Clk);
    endtask

    task automatic assert_rst();
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            rel0[i] = BIG; pend[i] = 1'b1; cause[i] = 2'b01;
        end
        #1;
        chk("async_out0",   32'(out0),   32'hF);
        chk("async_ready0", 32'(rdy0),   32'h0);
        chk("async_cause0", 32'(cause0), 32'h1);
        chk("async_out1",   32'(out1),   32'h3);
        chk("async_ready1", 32'(rdy1),   32'h0);
    endtask

    initial begin
        rst    = 1'b0;
        sw_req = 1'b0;
        for (int i = 0; i < 2; i++) begin
            rel0[i] = BIG; pend[i] = 1'b1; cause[i] = 2'b01;
        end
        #1;
        chk("pwr_out0",   32'(out0),   32'hF);
        chk("pwr_ready0", 32'(rdy0),   32'h0);
        chk("pwr_cause0", 32'(cause0), 32'h1);

        // Power-on with rst never asserted; sw_req at edge 20 must be ignored by dut0.
        for (int c = 0; c < 35; c++) step(edge_no + 1 == 20);

        // Software request from DONE.
        for (int c = 0; c < 3; c++) step(1'b0);
        step(1'b1);
        for (int c = 0; c < 31; c++) step(1'b0);

        // Sub-period rst pulse after ready.
        assert_rst();
        #2 rst = 1'b0;
        for (int c = 0; c < 24; c++) step(1'b0);

        // dut0 now at 1100: reassert rst mid-release and hold it two edges.
        chk("mid_out0", 32'(out0), 32'hC);
        assert_rst();
        step(1'b0);
        step(1'b0);
        rst = 1'b0;
        for (int c = 0; c < 34; c++) step(1'b0);

        // rst and sw_req together: rst wins.
        sw_req = 1'b1;
        assert_rst();
        step(1'b1);
        rst = 1'b0;
        for (int c = 0; c < 33; c++) step(1'b0);

        if (q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_leftover got=%0d exp=0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1);
    end

endmodule
